bin_checker: RTL and testbench
==============================

// Module: bin_checker
// PURPOSE
//  Downstream checker for univ_bin_counter. Samples the counter's control
//  inputs and its outputs (q, max_tick, min_tick) each clock. Runs a
//  registered reference model of the counter and flags any mismatch.
//  Keeps check/error statistics and captures the first failing sample for
//  bench or on-chip debug readout.
// PARAMETERS
//  N   3   counter data width; must match the counter under check
//  CW  16  width of the check and error statistic counters
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  syn_clr      in   1   counter control, as applied to the counter
//  load         in   1   counter control
//  en           in   1   counter control
//  up           in   1   counter control
//  d            in   N   counter load data
//  q            in   N   counter output under check
//  max_tick     in   1   counter output under check
//  min_tick     in   1   counter output under check
//  err          out  1   one-cycle pulse: mismatch seen in previous cycle
//  err_cnt      out  CW  number of mismatching cycles, saturating
//  chk_cnt      out  CW  number of cycles checked, saturating
//  first_vld    out  1   first-error capture valid; sticky until reset
//  first_q      out  N   observed q at the first error
//  first_exp    out  N   expected q at the first error
//  halted       out  1   checker stopped (HALT state)
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0; model q_exp=0; FSM=SYNC.
//  FSM: SYNC -> RUN -> (HALT, macro builds only).
//   SYNC: lasts one cycle after reset deassert. No compare is done. Then RUN.
//   RUN: compares on every clock edge.
//   HALT: counters, capture and model frozen; err=0. Exit only by reset.
//  Model next value, with priority as in the counter:
//   syn_clr -> 0
//   else load -> d
//   else en&up -> base+1
//   else en&~up -> base-1
//   else base
//  Wrap is modulo 2^N: 2^N-1 +1 -> 0, and 0 -1 -> 2^N-1.
//  base = q_exp normally. base = observed q in the cycle after a
//   mismatch (resync), so one fault yields one error, not a cascade.
//  Compare (RUN): mism = (q!=q_exp) | (max_tick!=(q_exp==2^N-1))
//   | (min_tick!=(q_exp==0)).
//  err is registered: it is high in the cycle after mism is sampled.
//   Latency is 1 clock.
//  chk_cnt += 1 each RUN cycle. err_cnt += 1 on each mism. Both saturate at
//   2^CW-1 and never wrap.
//  First mism with first_vld=0: latch first_q=q and first_exp=q_exp, and
//   set first_vld. Later errors do not overwrite the capture.
//  Simultaneous syn_clr+load+en: syn_clr wins (model matches the counter).
//  Reset asserted mid-run: immediate clear, and SYNC follows.
//  halted=1 only in HALT.
// CONFIGURATION
//  BIN_CHECKER_HALT_EN defined:
//   on the first mism, FSM goes RUN->HALT in the same edge that raises err.
//   err pulses once. The counters stop with err_cnt=1.
//  BIN_CHECKER_HALT_EN undefined:
//   no HALT state; halted is tied to 0. Checking continues with resync.
// TESTING
//  1 Reset then 8 cycles en=1,up=1 on correct counter ->
//    err never 1, err_cnt=0, chk_cnt=7 (SYNC cycle excluded).
//  2 Count up through 7 -> 0 (N=3) -> max_tick matches at q=7.
//    Then en=1,up=0 from 0 -> q=7, no error.
//  3 load=1,d=5 then syn_clr=1 with load=1,d=3 -> q_exp 5 then 0, no error.
//  4 Force q=4 when exp=2 -> err=1 next cycle, first_q=4, first_exp=2.
//    Model resyncs; no further errors.
//  5 HALT build, two forced mismatches -> halted=1 after the first,
//    err_cnt=1, chk_cnt frozen.
//  6 Assert reset mid-count -> all outputs 0 asynchronously.
//    One SYNC cycle, then checking resumes.

Source files
------------

// File: rtl/bin_checker.sv
// rtl/bin_checker.sv - registered reference-model checker for univ_bin_counter
// Optional halt-on-first-error behaviour is enabled by defining BIN_CHECKER_HALT_EN.
module bin_checker #(
    parameter int N  = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          syn_clr,
    input  logic          load,
    input  logic          en,
    input  logic          up,
    input  logic [N-1:0]  d,
    input  logic [N-1:0]  q,
    input  logic          max_tick,
    input  logic          min_tick,
    output logic          err,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] chk_cnt,
    output logic          first_vld,
    output logic [N-1:0]  first_q,
    output logic [N-1:0]  first_exp,
    output logic          halted
);

    localparam logic [N-1:0]  Q_MAX   = {N{1'b1}};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1
`ifdef BIN_CHECKER_HALT_EN
        , HALT = 2'd2
`endif
    } state_t;

    state_t       state, state_nxt;
    logic         mism;
    logic         frozen;
    logic [N-1:0] q_exp, base, q_exp_nxt;

    always_comb begin
        mism      = 1'b0;
        frozen    = 1'b0;
        state_nxt = state;
        if (state == RUN) begin
            mism = (q != q_exp) | (max_tick != (q_exp == Q_MAX)) | (min_tick != (q_exp == '0));
        end
        // After a mismatch the model follows the observed counter, so a single fault is reported once.
        base = mism ? q : q_exp;
        if (syn_clr)
            q_exp_nxt = '0;
        else if (load)
            q_exp_nxt = d;
        else if (en && up)
            q_exp_nxt = base + N'(1);
        else if (en)
            q_exp_nxt = base - N'(1);
        else
            q_exp_nxt = base;
        case (state)
            SYNC: state_nxt = RUN;
            RUN: begin
`ifdef BIN_CHECKER_HALT_EN
                if (mism)
                    state_nxt = HALT;
`endif
            end
`ifdef BIN_CHECKER_HALT_EN
            HALT: frozen = 1'b1;
`endif
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SYNC;
            q_exp     <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
            chk_cnt   <= '0;
            first_vld <= 1'b0;
            first_q   <= '0;
            first_exp <= '0;
        end else begin
            state <= state_nxt;
            if (frozen) begin
                err <= 1'b0;
            end else begin
                q_exp <= q_exp_nxt;
                err   <= mism;
                if (state == RUN && chk_cnt != CNT_MAX)
                    chk_cnt <= chk_cnt + CW'(1);
                if (mism && err_cnt != CNT_MAX)
                    err_cnt <= err_cnt + CW'(1);
                if (mism && !first_vld) begin
                    first_vld <= 1'b1;
                    first_q   <= q;
                    first_exp <= q_exp;
                end
            end
        end
    end

`ifdef BIN_CHECKER_HALT_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_bin_checker.sv
// tb/tb_bin_checker.sv - scoreboard bench for bin_checker driving a behavioural 3-bit counter
// Expectations for the halt build are selected with BIN_CHECKER_HALT_EN.
module tb_bin_checker;

    localparam int N  = 3;
    localparam int CW = 4;
`ifdef BIN_CHECKER_HALT_EN
    localparam bit HALT_BUILD = 1'b1;
`else
    localparam bit HALT_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          syn_clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0;
    logic [N-1:0]  d = '0;
    logic          jump = 1'b0, glitch = 1'b0;
    logic [N-1:0]  jump_val = '0, glitch_val = '0;
    logic [N-1:0]  cnt, q;
    logic          max_tick, min_tick;
    logic          err, first_vld, halted;
    logic [CW-1:0] err_cnt, chk_cnt;
    logic [N-1:0]  first_q, first_exp;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    // Counter under check; jump corrupts its state, glitch corrupts only its output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cnt <= '0;
        else if (jump)    cnt <= jump_val;
        else if (syn_clr) cnt <= '0;
        else if (load)    cnt <= d;
        else if (en)      cnt <= up ? cnt + 3'd1 : cnt - 3'd1;
    end
    assign q        = glitch ? glitch_val : cnt;
    assign max_tick = (q == 3'd7);
    assign min_tick = (q == 3'd0);

    bin_checker #(.N(N), .CW(CW)) dut (
        .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d),
        .q(q), .max_tick(max_tick), .min_tick(min_tick), .err(err), .err_cnt(err_cnt),
        .chk_cnt(chk_cnt), .first_vld(first_vld), .first_q(first_q), .first_exp(first_exp),
        .halted(halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic c, input logic l, input logic e, input logic u,
                        input logic [N-1:0] dv, input logic jmp, input logic [N-1:0] jv,
                        input logic exp_err);
        syn_clr = c; load = l; en = e; up = u; d = dv; jump = jmp; jump_val = jv;
        exp_q.push_back(exp_err);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_chk_cnt"}, chk_cnt, 0);
        chk({tag, "_first_vld"}, first_vld, 0);
        chk({tag, "_first_q"}, first_q, 0);
        chk({tag, "_first_exp"}, first_exp, 0);
        chk({tag, "_halted"}, halted, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin : monitor
        logic e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (err !== e) begin
                    errors++;
                    $display("FAIL err_pulse: got %b want %b (t=%0t)", err, e, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        do_reset("rst0");

        // Correct counter counting up: SYNC edge excluded from checks.
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0, 0, 0, 0);
        chk("up8_err_cnt", err_cnt, 0);
        chk("up8_chk_cnt", chk_cnt, 7);

        // Through 7 -> 0, then down from 0 to 7; chk_cnt reaches 17 and saturates at 15.
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_err_cnt", err_cnt, 0);
        chk("sat_chk_cnt", chk_cnt, 15);
        chk("wrap_first_vld", first_vld, 0);

        // Load 5, then syn_clr beats load/en.
        do_reset("rst1");
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 5, 0, 0, 0);
        step(1, 1, 1, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("prio_err_cnt", err_cnt, 0);
        chk("prio_chk_cnt", chk_cnt, 3);

        // Counter jumps to 4 where 2 is expected, later to 0 where 6 is expected.
        do_reset("rst2");
        step(0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 1, 4, 0);
        step(0, 0, 1, 1, 0, 0, 0, 1);
        step(0, 0, 1, 1, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, HALT_BUILD ? 1'b0 : 1'b1);
        chk("fault_first_vld", first_vld, 1);
        chk("fault_first_q", first_q, 4);
        chk("fault_first_exp", first_exp, 2);
        chk("fault_err_cnt", err_cnt, HALT_BUILD ? 1 : 2);
        chk("fault_chk_cnt", chk_cnt, HALT_BUILD ? 2 : 4);
        chk("fault_halted", halted, HALT_BUILD ? 1 : 0);

        // Mid-run async reset, then a corrupted q during SYNC must not be compared.
        do_reset("rst3");
        glitch = 1'b1; glitch_val = 3'd3;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        glitch = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 0, 0);
        chk("resume_err_cnt", err_cnt, 0);
        chk("resume_chk_cnt", chk_cnt, 3);
        chk("resume_first_vld", first_vld, 0);

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
